ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes to the keyboard: 0xED LED set, 0xFF reset, 0xF3 typematic.
- Opposite direction to the existing scancode receive path; shares the same PS2_CLK/PS2_DAT lines through open-collector enables.
- Runs on clk_bus. Exports tx_busy so the receive path ignores line activity while a command frame is in flight.

Parameters:
- CLK_KHZ, 24000, clk_bus frequency in kHz; all timing derives from it.
- INHIBIT_US, 100, time the host holds CLK low before request-to-send.
- START_TO_US, 15000, maximum wait from CLK release to the device's first falling edge.
- FRAME_TO_US, 2000, maximum wait between consecutive device CLK falling edges.
- FILT_LEN, 8, clk_bus cycles a synchronised line must be stable before its filtered value changes.

Ports:
- clk_bus  in  1  system clock
- bus_reset_n  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send; captured on an accepted tx_stb
- tx_stb  in  1  one-cycle request; accepted only when tx_busy=0
- tx_busy  out  1  high from the cycle after accept until the tx_done cycle inclusive
- tx_done  out  1  one-cycle pulse at the end of every accepted frame
- tx_err  out  2  valid while tx_done=1: 00 ok, 01 start timeout, 10 frame timeout, 11 NACK
- ps2_clk_in  in  1  raw CLK line level
- ps2_dat_in  in  1  raw DAT line level
- ps2_clk_oe  out  1  1 = pull CLK low
- ps2_dat_oe  out  1  1 = pull DAT low

Behaviour:
- Reset (async, bus_reset_n=0): tx_busy=0, tx_done=0, tx_err=00, ps2_clk_oe=0, ps2_dat_oe=0, state IDLE, counters 0. Reset mid-frame releases both lines immediately; no partial completion pulse.
- Inputs: 2-flop synchroniser, then FILT_LEN stability filter. A CLK falling edge is filtered level 1->0, registered, so it arrives 1 cycle after the filter output changes.
- On accept: shreg <= {~^tx_data, tx_data}, giving odd parity as bit 8. Bit counter = 0.
- IDLE: on tx_stb, go to INHIBIT and assert clk_oe=1 in the next cycle.
- INHIBIT: hold clk_oe=1 for CLK_KHZ*INHIBIT_US/1000 cycles. In the last cycle set dat_oe=1 (start bit), then go to RTS with clk_oe=0.
- RTS: wait for a CLK falling edge; timeout START_TO_US -> FAIL(01). On the edge: dat_oe = ~shreg[0], shift right, go to DATA.
- DATA: on each falling edge drive the next bit. Bit order: data 1..7, then parity, i.e. edges 2..9.
- STOP: edge 10 sets dat_oe=0 (stop bit released high).
- ACK: on edge 11, sample filtered DAT. Low = ack, go to WAIT_IDLE; high = FAIL(11).
- Inter-edge timeout: FRAME_TO_US, counted from the previous edge, applies in DATA/STOP/ACK. Expiry -> FAIL(10).
- WAIT_IDLE: wait until filtered CLK=1 and DAT=1, bounded by FRAME_TO_US (expiry -> FAIL(10)). Then pulse tx_done with tx_err=00 and return to IDLE.
- FAIL(code): release both oe, pulse tx_done with tx_err=code, return to IDLE. The receive path must tolerate a stray partial frame.
- tx_stb while busy: ignored, no queue, no error. tx_stb in the tx_done cycle is also ignored.
- Counters: a single timer register sized for the largest of the three timeouts, in cycles; saturates, no wrap. 4-bit edge counter.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, RTS, DATA, STOP, ACK, WAIT_IDLE, FAIL
  - tx_err codes
  - command constants: CMD_LED=0xED, CMD_RESET=0xFF, CMD_TYPEMATIC=0xF3, RSP_ACK=0xFA, RSP_RESEND=0xFE
  - function us_to_cyc
- Sub-module ps2_line_filt: synchroniser, stability filter and falling-edge detect for one line, instantiated twice. The receive path adopts it later.

Test Plan:
- Sim with CLK_KHZ=1000, FILT_LEN=2, device model clocking at a 40-cycle period.
  - Send 0xED -> clk_oe high exactly 100 cycles; start bit 0; device samples bits LSB first 1,0,1,1,0,1,1,1; parity 1; stop 1; model ACKs low -> one tx_done, tx_err=00, busy low next cycle.
  - Send 0x00 -> device-sampled parity=1. Send 0x01 -> parity=0.
- Device never clocks after RTS -> tx_done with tx_err=01 at 15000 cycles after CLK release; both oe=0.
- Device stops after the 5th edge -> tx_err=10 2000 cycles after the last edge.
- Device leaves DAT high at edge 11 -> tx_err=11.
- bus_reset_n low during DATA -> both oe drop asynchronously, tx_busy=0, no tx_done. A new tx_stb after reset completes normally.
- tx_stb again during busy with 0x55 -> ignored; the first byte 0xFF completes and the sampled frame contains 0xFF only.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, keyboard command bytes and timing helpers for the PS/2 host path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      DATA,
      STOP,
      ACK,
      WAIT_IDLE,
      FAIL
   } tx_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_START_TO = 2'b01,
      ERR_FRAME_TO = 2'b10,
      ERR_NACK     = 2'b11
   } tx_err_e;

   localparam logic [7:0] CMD_LED       = 8'hED;
   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
   localparam logic [7:0] RSP_ACK       = 8'hFA;
   localparam logic [7:0] RSP_RESEND    = 8'hFE;

   function automatic int unsigned us_to_cyc(input int unsigned clk_khz, input int unsigned us);
      return (clk_khz * us) / 1000;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ps2_line_filt.sv
// One PS/2 line: two-flop synchroniser, stability filter and registered falling-edge pulse.
module ps2_line_filt
   import ps2_pkg::*;
#(
   parameter int unsigned FILT_LEN = 8
) (
   input  logic clk_bus,
   input  logic bus_reset_n,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

   logic [1:0]    sync_q;
   logic          filt_q, filt_d;
   logic          prev_q;
   logic          fall_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Lines idle high, so everything resets to the released level.
   always_ff @(posedge clk_bus or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         filt_q <= filt_d;
         prev_q <= filt_q;
         fall_q <= prev_q & ~filt_q;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign level_o = filt_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving the shared CLK/DAT lines via open-collector enables.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_KHZ     = 24000,
   parameter int unsigned INHIBIT_US  = 100,
   parameter int unsigned START_TO_US = 15000,
   parameter int unsigned FRAME_TO_US = 2000,
   parameter int unsigned FILT_LEN    = 8
) (
   input  logic       clk_bus,
   input  logic       bus_reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_stb,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [1:0] tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned INHIBIT_CYC = us_to_cyc(CLK_KHZ, INHIBIT_US);
   localparam int unsigned START_CYC   = us_to_cyc(CLK_KHZ, START_TO_US);
   localparam int unsigned FRAME_CYC   = us_to_cyc(CLK_KHZ, FRAME_TO_US);
   localparam int unsigned MAX_CYC     = max_u(INHIBIT_CYC, max_u(START_CYC, FRAME_CYC));
   localparam int unsigned TW          = $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] START_BIT_AT = TW'(INHIBIT_CYC - 2);
   localparam logic [TW-1:0] START_LAST   = TW'(START_CYC - 1);
   localparam logic [TW-1:0] FRAME_LAST   = TW'(FRAME_CYC - 1);
   localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    edge_cnt_q, edge_cnt_d;
   logic [8:0]    shreg_q, shreg_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    err_q, err_d;
   tx_err_e       fail_code_q, fail_code_d;
   logic          fail_req;

   logic clk_level, clk_fall;
   logic dat_level, dat_fall_unused;

   ps2_line_filt #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_bus     (clk_bus),
      .bus_reset_n (bus_reset_n),
      .line_i      (ps2_clk_in),
      .level_o     (clk_level),
      .fall_o      (clk_fall)
   );

   ps2_line_filt #(.FILT_LEN(FILT_LEN)) u_dat_filt (
      .clk_bus     (clk_bus),
      .bus_reset_n (bus_reset_n),
      .line_i      (ps2_dat_in),
      .level_o     (dat_level),
      .fall_o      (dat_fall_unused)
   );

   always_ff @(posedge clk_bus or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         edge_cnt_q  <= '0;
         shreg_q     <= '0;
         clk_oe_q    <= 1'b0;
         dat_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ERR_OK;
         fail_code_q <= ERR_OK;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         edge_cnt_q  <= edge_cnt_d;
         shreg_q     <= shreg_d;
         clk_oe_q    <= clk_oe_d;
         dat_oe_q    <= dat_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fail_code_q <= fail_code_d;
      end
   end

   // The timer restarts on every state change or device edge and otherwise saturates.
   always_comb begin
      state_d     = state_q;
      timer_d     = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
      edge_cnt_d  = edge_cnt_q;
      shreg_d     = shreg_q;
      clk_oe_d    = clk_oe_q;
      dat_oe_d    = dat_oe_q;
      done_d      = 1'b0;
      err_d       = ERR_OK;
      fail_code_d = fail_code_q;
      fail_req    = 1'b0;

      case (state_q)
         IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (tx_stb && !busy_q) begin
               shreg_d    = {~^tx_data, tx_data};
               edge_cnt_d = '0;
               timer_d    = '0;
               clk_oe_d   = 1'b1;
               state_d    = INHIBIT;
            end
         end

         INHIBIT: begin
            if (timer_q == START_BIT_AT) begin
               dat_oe_d = 1'b1;
            end
            if (timer_q >= INHIBIT_LAST) begin
               clk_oe_d = 1'b0;
               timer_d  = '0;
               state_d  = RTS;
            end
         end

         RTS: begin
            if (clk_fall) begin
               dat_oe_d   = ~shreg_q[0];
               shreg_d    = shreg_q >> 1;
               edge_cnt_d = 4'd1;
               timer_d    = '0;
               state_d    = DATA;
            end else if (timer_q >= START_LAST) begin
               fail_req    = 1'b1;
               fail_code_d = ERR_START_TO;
            end
         end

         // Edges 2..9 carry data bits 1..7 and then the parity bit.
         DATA: begin
            if (clk_fall) begin
               dat_oe_d   = ~shreg_q[0];
               shreg_d    = shreg_q >> 1;
               edge_cnt_d = edge_cnt_q + 4'd1;
               timer_d    = '0;
               if (edge_cnt_q == 4'd8) begin
                  state_d = STOP;
               end
            end else if (timer_q >= FRAME_LAST) begin
               fail_req    = 1'b1;
               fail_code_d = ERR_FRAME_TO;
            end
         end

         STOP: begin
            if (clk_fall) begin
               dat_oe_d   = 1'b0;
               edge_cnt_d = edge_cnt_q + 4'd1;
               timer_d    = '0;
               state_d    = ACK;
            end else if (timer_q >= FRAME_LAST) begin
               fail_req    = 1'b1;
               fail_code_d = ERR_FRAME_TO;
            end
         end

         ACK: begin
            if (clk_fall) begin
               edge_cnt_d = edge_cnt_q + 4'd1;
               timer_d    = '0;
               if (!dat_level) begin
                  state_d = WAIT_IDLE;
               end else begin
                  fail_req    = 1'b1;
                  fail_code_d = ERR_NACK;
               end
            end else if (timer_q >= FRAME_LAST) begin
               fail_req    = 1'b1;
               fail_code_d = ERR_FRAME_TO;
            end
         end

         WAIT_IDLE: begin
            if (clk_level && dat_level) begin
               done_d  = 1'b1;
               err_d   = ERR_OK;
               state_d = IDLE;
            end else if (timer_q >= FRAME_LAST) begin
               fail_req    = 1'b1;
               fail_code_d = ERR_FRAME_TO;
            end
         end

         FAIL: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b1;
            err_d    = fail_code_q;
            state_d  = IDLE;
         end

         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
      endcase

      if (fail_req) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         timer_d  = '0;
         state_d  = FAIL;
      end
   end

   // Busy stays up through the done cycle so a strobe landing there is dropped.
   always_comb begin
      busy_d = (state_d != IDLE) || done_d;
   end

   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_err     = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks the frame, a monitor checks each tx_done.
module tb_ps2_host_tx;

   localparam int MODE_NORMAL = 0;
   localparam int MODE_SILENT = 1;
   localparam int MODE_STALL  = 2;
   localparam int MODE_NACK   = 3;

   typedef struct {
      logic [1:0] err;
      logic [7:0] data;
      logic       parity;
      bit         chkFrame;
      int         timing;
   } exp_t;

   logic       clk_bus = 1'b0;
   logic       bus_reset_n = 1'b1;
   logic [7:0] tx_data;
   logic       tx_stb;
   logic       tx_busy;
   logic       tx_done;
   logic [1:0] tx_err;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;

   logic       devClkLow = 1'b0;
   logic       devDatLow = 1'b0;
   logic       devPrevOe = 1'b0;
   logic       devStart = 1'b1;
   logic [9:0] devBits = '0;
   int         devEdges = 0;
   bit         devActive = 1'b0;
   int         devMode = MODE_NORMAL;

   exp_t expQ[$];
   exp_t expCur;
   int   checks = 0;
   int   errors = 0;
   int   doneCount = 0;
   int   oeRun = 0;
   int   lastInhibit = 0;
   int   relCnt = 0;
   int   fallCnt = 0;
   logic prevClkOe = 1'b0;
   logic prevRawClk = 1'b1;
   bit   busyNextPending = 1'b0;

   always #5 clk_bus = ~clk_bus;

   assign ps2_clk_in = ~(ps2_clk_oe | devClkLow);
   assign ps2_dat_in = ~(ps2_dat_oe | devDatLow);

   ps2_host_tx #(
      .CLK_KHZ     (1000),
      .INHIBIT_US  (100),
      .START_TO_US (15000),
      .FRAME_TO_US (2000),
      .FILT_LEN    (2)
   ) dut (
      .clk_bus     (clk_bus),
      .bus_reset_n (bus_reset_n),
      .tx_data     (tx_data),
      .tx_stb      (tx_stb),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_dat_in  (ps2_dat_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_dat_oe  (ps2_dat_oe)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_bus);
   endtask

   // Device side: clocks 40-cycle bits, samples on the rising half, answers edge 11 per mode.
   task automatic runFrame();
      devActive = 1'b1;
      devEdges  = 0;
      devBits   = '0;
      devStart  = ps2_dat_in;
      waitCycles(10);
      for (int i = 1; i <= 10; i++) begin
         if (devMode == MODE_STALL && i == 6) begin
            devActive = 1'b0;
            return;
         end
         devClkLow = 1'b1;
         devEdges  = i;
         waitCycles(20);
         devClkLow = 1'b0;
         waitCycles(10);
         devBits[i-1] = ps2_dat_in;
         waitCycles(10);
      end
      if (devMode != MODE_NACK) devDatLow = 1'b1;
      waitCycles(5);
      devClkLow = 1'b1;
      devEdges  = 11;
      waitCycles(20);
      devClkLow = 1'b0;
      waitCycles(5);
      devDatLow = 1'b0;
      devActive = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk_bus);
         if (devPrevOe && !ps2_clk_oe && devMode != MODE_SILENT) runFrame();
         devPrevOe = ps2_clk_oe;
      end
   end

   // Monitor: line-history counters plus scoreboard pop on every tx_done.
   always @(negedge clk_bus) begin
      if (ps2_clk_oe) begin
         oeRun++;
      end else begin
         if (oeRun != 0) lastInhibit = oeRun;
         oeRun = 0;
      end
      if (prevClkOe && !ps2_clk_oe) relCnt = 0;
      else relCnt++;
      prevClkOe = ps2_clk_oe;
      if (prevRawClk && !ps2_clk_in) fallCnt = 0;
      else fallCnt++;
      prevRawClk = ps2_clk_in;

      if (busyNextPending) begin
         checkOutput("busyAfterDone", int'(tx_busy), 0);
         busyNextPending = 1'b0;
      end

      if (tx_done) begin
         doneCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
         end else begin
            expCur = expQ.pop_front();
            checkOutput("txErr", int'(tx_err), int'(expCur.err));
            checkOutput("busyInDone", int'(tx_busy), 1);
            checkOutput("clkOeAtDone", int'(ps2_clk_oe), 0);
            checkOutput("datOeAtDone", int'(ps2_dat_oe), 0);
            if (expCur.chkFrame) begin
               checkOutput("inhibitCycles", lastInhibit, 100);
               checkOutput("startBit", int'(devStart), 0);
               checkOutput("frameData", int'(devBits[7:0]), int'(expCur.data));
               checkOutput("frameParity", int'(devBits[8]), int'(expCur.parity));
               checkOutput("stopBit", int'(devBits[9]), 1);
            end
            if (expCur.timing == 1) checkRange("startTimeoutCycles", relCnt, 15000, 15003);
            if (expCur.timing == 2) checkRange("frameTimeoutCycles", fallCnt, 2000, 2012);
            busyNextPending = 1'b1;
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] data, input int mode, input logic [1:0] err,
                                input logic parity, input int timing);
      exp_t e;
      int   n = 0;
      while ((tx_busy || devActive) && n < 3000) begin
         @(negedge clk_bus);
         n++;
      end
      devMode    = mode;
      e.err      = err;
      e.data     = data;
      e.parity   = parity;
      e.chkFrame = (mode == MODE_NORMAL) || (mode == MODE_NACK);
      e.timing   = timing;
      expQ.push_back(e);
      @(negedge clk_bus);
      tx_data = data;
      tx_stb  = 1'b1;
      @(negedge clk_bus);
      tx_stb  = 1'b0;
   endtask

   task automatic waitDone(input int limit);
      int start = doneCount;
      int n = 0;
      while (doneCount == start && n < limit) begin
         @(negedge clk_bus);
         n++;
      end
      if (doneCount == start) checkOutput("doneTimeout", 0, 1);
   endtask

   initial begin
      int n;
      int doneBefore;
      tx_stb  = 1'b0;
      tx_data = 8'h00;
      #2 bus_reset_n = 1'b0;
      waitCycles(4);
      checkOutput("resetBusy", int'(tx_busy), 0);
      checkOutput("resetDone", int'(tx_done), 0);
      checkOutput("resetErr", int'(tx_err), 0);
      checkOutput("resetClkOe", int'(ps2_clk_oe), 0);
      checkOutput("resetDatOe", int'(ps2_dat_oe), 0);
      bus_reset_n = 1'b1;
      waitCycles(20);

      applyStimulus(8'hED, MODE_NORMAL, 2'b00, 1'b1, 0);
      waitDone(2000);
      applyStimulus(8'h00, MODE_NORMAL, 2'b00, 1'b1, 0);
      waitDone(2000);
      applyStimulus(8'h01, MODE_NORMAL, 2'b00, 1'b0, 0);
      waitDone(2000);
      applyStimulus(8'h12, MODE_SILENT, 2'b01, 1'b0, 1);
      waitDone(16000);
      applyStimulus(8'h34, MODE_STALL, 2'b10, 1'b0, 2);
      waitDone(4000);
      applyStimulus(8'hC3, MODE_NACK, 2'b11, 1'b1, 0);
      waitDone(2000);

      // Reset in the middle of the data phase.
      n = 0;
      while ((tx_busy || devActive) && n < 3000) begin
         @(negedge clk_bus);
         n++;
      end
      devMode = MODE_NORMAL;
      @(negedge clk_bus);
      tx_data = 8'hA5;
      tx_stb  = 1'b1;
      @(negedge clk_bus);
      tx_stb  = 1'b0;
      n = 0;
      while (!(devActive && devEdges >= 4) && n < 2000) begin
         @(negedge clk_bus);
         n++;
      end
      if (!(devActive && devEdges >= 4)) checkOutput("reachDataPhase", 0, 1);
      waitCycles(10);
      checkOutput("datOeBeforeReset", int'(ps2_dat_oe), 1);
      doneBefore = doneCount;
      #2 bus_reset_n = 1'b0;
      #1;
      checkOutput("asyncResetClkOe", int'(ps2_clk_oe), 0);
      checkOutput("asyncResetDatOe", int'(ps2_dat_oe), 0);
      checkOutput("asyncResetBusy", int'(tx_busy), 0);
      waitCycles(3);
      bus_reset_n = 1'b1;
      n = 0;
      while (devActive && n < 2000) begin
         @(negedge clk_bus);
         n++;
      end
      waitCycles(50);
      checkOutput("noDoneAfterReset", doneCount - doneBefore, 0);

      applyStimulus(8'hF3, MODE_NORMAL, 2'b00, 1'b1, 0);
      waitDone(2000);

      // 0xFF with a strobe mid-frame and another in the done cycle; neither may start a frame.
      applyStimulus(8'hFF, MODE_NORMAL, 2'b00, 1'b1, 0);
      doneBefore = doneCount;
      waitCycles(30);
      tx_data = 8'h55;
      tx_stb  = 1'b1;
      @(negedge clk_bus);
      tx_stb  = 1'b0;
      n = 0;
      while (!tx_done && n < 2000) begin
         @(negedge clk_bus);
         n++;
      end
      if (!tx_done) checkOutput("doneTimeoutFF", 0, 1);
      tx_data = 8'h55;
      tx_stb  = 1'b1;
      @(negedge clk_bus);
      tx_stb  = 1'b0;
      waitCycles(20);
      checkOutput("idleAfterStbInDone", int'(tx_busy), 0);
      checkOutput("noInhibitAfterStbInDone", int'(ps2_clk_oe), 0);
      checkOutput("singleDoneForFF", doneCount - doneBefore, 1);
      checkOutput("pendingExpectations", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
